// File: rtl/display_scan_driver_pkg.sv
// Shared constants and helpers for the display scan driver and its BCD converter.
package display_pkg;
  localparam int         NUM_DIGITS = 4;
  localparam int         BCD_W      = 4;
  localparam int         VALUE_W    = 14;
  localparam logic [13:0] MAX_VALUE = 14'd9999;
  localparam int         CONV_STEPS = 14;
  localparam logic [3:0] AN_ALL_OFF = 4'b1111;

  typedef enum logic {S_IDLE, S_SHIFT} conv_state_e;

  // Double-dabble correction: any nibble >= 5 gets +3 before the shift.
  function automatic logic [15:0] dabble_adj(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (r[i*BCD_W +: BCD_W] >= 4'd5) r[i*BCD_W +: BCD_W] = r[i*BCD_W +: BCD_W] + 4'd3;
    return r;
  endfunction
endpackage

// File: rtl/display_scan_driver_if.sv
// Request/display bundle between the vending controller and the scan driver.
interface display_scan_driver_if;
  logic [13:0] value;
  logic        load;
  logic        busy;
  logic        done;
  logic        ovf;
  logic [3:0]  digit_code;
  logic [3:0]  an;

  modport master (output value, load, input busy, done, ovf, digit_code, an);
  modport slave  (input value, load, output busy, done, ovf, digit_code, an);
endinterface

// File: rtl/display_scan_driver_bin2bcd_seq.sv
// Sequential 14-bit binary to 4-digit BCD converter (shift-add-3), one bit per clock.
module bin2bcd_seq
  import display_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [13:0] bin,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd
);
  conv_state_e r_state, w_state_nxt;
  logic [29:0] r_sr;
  logic [3:0]  r_cnt;
  logic        r_done;
  logic [15:0] r_bcd;
  logic        w_last;
  logic [29:0] w_sr_step;

  assign w_last    = (r_cnt == 4'(CONV_STEPS - 1));
  assign w_sr_step = {dabble_adj(r_sr[29:14]), r_sr[13:0]} << 1;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start)  w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // r_bcd is the display register: it only changes when a full conversion lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr   <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
      r_bcd  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_sr  <= {16'd0, bin};
          r_cnt <= '0;
        end
        S_SHIFT: begin
          r_sr  <= w_sr_step;
          r_cnt <= r_cnt + 4'd1;
          if (w_last) begin
            r_bcd  <= w_sr_step[29:14];
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state == S_SHIFT);
  assign done = r_done;
  assign bcd  = r_bcd;
endmodule

// File: rtl/display_scan_driver.sv
// Converts a binary amount to BCD and time-multiplexes four digits onto one 7-seg decoder.
module display_scan_driver
  import display_pkg::*;
#(
  parameter int REFRESH_DIV   = 100000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  display_scan_driver_if.slave  bus
);
  localparam int PW = $clog2(REFRESH_DIV);

  logic [PW-1:0]         r_presc;
  logic [1:0]            r_idx;
  logic [3:0]            r_code;
  logic [3:0]            r_an;
  logic                  r_ovf;
  logic                  w_busy, w_done, w_wrap, w_nz, w_over;
  logic [13:0]           w_sat;
  logic [15:0]           w_bcd;
  logic [1:0]            w_idx_nxt;
  logic [NUM_DIGITS-1:0] w_blank;

  assign w_over = (bus.value > MAX_VALUE);
  assign w_sat  = w_over ? MAX_VALUE : bus.value;

  bin2bcd_seq u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (bus.load),
    .bin   (w_sat),
    .busy  (w_busy),
    .done  (w_done),
    .bcd   (w_bcd)
  );

  // A digit is blanked when it and every digit above it are zero; ones never blanks.
  always_comb begin
    w_nz       = 1'b0;
    w_blank    = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      w_nz       = w_nz | (w_bcd[i*BCD_W +: BCD_W] != 4'd0);
      w_blank[i] = BLANK_LEADING & ~w_nz;
    end
  end

  assign w_wrap    = (r_presc == PW'(REFRESH_DIV - 1));
  assign w_idx_nxt = w_wrap ? r_idx + 2'd1 : r_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
      r_idx   <= '0;
      r_code  <= '0;
      r_an    <= AN_ALL_OFF;
      r_ovf   <= 1'b0;
    end else begin
      r_presc <= w_wrap ? '0 : r_presc + 1'b1;
      r_idx   <= w_idx_nxt;
      r_code  <= w_bcd[{w_idx_nxt, 2'b00} +: BCD_W];
      r_an    <= w_blank[w_idx_nxt] ? AN_ALL_OFF : ~(4'b0001 << w_idx_nxt);
      if (bus.load && !w_busy) r_ovf <= w_over;
    end
  end

  assign bus.busy       = w_busy;
  assign bus.done       = w_done;
  assign bus.ovf        = r_ovf;
  assign bus.digit_code = r_code;
  assign bus.an         = r_an;
endmodule

// File: tb/tb_display_scan_driver.sv
// Directed bench: two instances (leading-zero blanking on/off) with REFRESH_DIV=4.
module tb_display_scan_driver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   tick  = 0;

  always #5 clk = ~clk;

  display_scan_driver_if bus_a ();
  display_scan_driver_if bus_b ();

  display_scan_driver #(.REFRESH_DIV(4), .BLANK_LEADING(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  display_scan_driver #(.REFRESH_DIV(4), .BLANK_LEADING(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  // Edges since reset release: prescaler = tick%4, scan index = (tick/4)%4.
  always @(posedge clk) begin
    if (rst) tick <= 0;
    else     tick <= tick + 1;
  end

  task automatic check_frame(input bit inst_b, input logic [15:0] exp_an,
                             input logic [15:0] exp_code, input string name);
    int w;
    logic [3:0] a, c;
    w = 0;
    while ((tick % 16) != 1 && w < 20) begin @(negedge clk); w++; end
    n_cmp++;
    if ((tick % 16) != 1) begin
      n_err++;
      $display("FAIL %s frame_sync: no frame start within 20 cycles", name);
    end else begin
      for (int s = 0; s < 4; s++) begin
        a = inst_b ? bus_b.an : bus_a.an;
        c = inst_b ? bus_b.digit_code : bus_a.digit_code;
        n_cmp++;
        if (a !== exp_an[s*4 +: 4]) begin
          n_err++;
          $display("FAIL %s an slot%0d: got %b expected %b", name, s, a, exp_an[s*4 +: 4]);
        end
        n_cmp++;
        if (c !== exp_code[s*4 +: 4]) begin
          n_err++;
          $display("FAIL %s code slot%0d: got %0d expected %0d", name, s, c, exp_code[s*4 +: 4]);
        end
        repeat (4) @(negedge clk);
      end
    end
  endtask

  // Issues one load to both instances and watches instance A for 30 cycles.
  task automatic run_load(input logic [13:0] v, input int ign_at, input logic [13:0] v2,
                          input int rst_at, output int bc, output int dc, output logic rb);
    bit did_ign, did_rst;
    did_ign = 0; did_rst = 0; rb = 1'bx;
    @(negedge clk);
    bus_a.value = v; bus_b.value = v; bus_a.load = 1'b1; bus_b.load = 1'b1;
    @(negedge clk);
    bus_a.load = 1'b0; bus_b.load = 1'b0;
    bc = 0; dc = 0;
    for (int c = 0; c < 30; c++) begin
      if (bus_a.busy) bc++;
      if (bus_a.done) dc++;
      if (ign_at > 0 && !did_ign && bc == ign_at) begin
        did_ign = 1;
        bus_a.value = v2; bus_b.value = v2; bus_a.load = 1'b1; bus_b.load = 1'b1;
      end
      if (rst_at > 0 && !did_rst && bc == rst_at) begin
        did_rst = 1;
        rst = 1'b1;
        @(negedge clk);
        rb  = bus_a.busy;
        rst = 1'b0;
      end else begin
        @(negedge clk);
      end
      bus_a.load = 1'b0; bus_b.load = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus_a.busy !== 1'b0) begin n_err++; $display("FAIL reset busy: got %b expected 0", bus_a.busy); end
    n_cmp++; if (bus_a.done !== 1'b0) begin n_err++; $display("FAIL reset done: got %b expected 0", bus_a.done); end
    n_cmp++; if (bus_a.ovf !== 1'b0) begin n_err++; $display("FAIL reset ovf: got %b expected 0", bus_a.ovf); end
    n_cmp++; if (bus_a.an !== 4'b1111) begin n_err++; $display("FAIL reset an: got %b expected 1111", bus_a.an); end
    n_cmp++; if (bus_a.digit_code !== 4'd0) begin n_err++; $display("FAIL reset code: got %0d expected 0", bus_a.digit_code); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus_a.an !== 4'b1110) begin n_err++; $display("FAIL first_slot an: got %b expected 1110", bus_a.an); end
    check_frame(0, 16'b1111_1111_1111_1110, 16'h0000, "reset_a");
    check_frame(1, 16'b0111_1011_1101_1110, 16'h0000, "reset_b");
  endtask

  task automatic test_conversion();
    int bc, dc; logic rb;
    run_load(14'd1234, 0, 14'd0, 0, bc, dc, rb);
    n_cmp++; if (bc != 14) begin n_err++; $display("FAIL conv busy_cycles: got %0d expected 14", bc); end
    n_cmp++; if (dc != 1) begin n_err++; $display("FAIL conv done_pulses: got %0d expected 1", dc); end
    n_cmp++; if (bus_a.ovf !== 1'b0) begin n_err++; $display("FAIL conv ovf: got %b expected 0", bus_a.ovf); end
    check_frame(0, 16'b0111_1011_1101_1110, 16'h1234, "conv_1234_a");
    check_frame(1, 16'b0111_1011_1101_1110, 16'h1234, "conv_1234_b");
  endtask

  task automatic test_blanking();
    int bc, dc; logic rb;
    run_load(14'd7, 0, 14'd0, 0, bc, dc, rb);
    n_cmp++; if (dc != 1) begin n_err++; $display("FAIL blank done_pulses: got %0d expected 1", dc); end
    check_frame(0, 16'b1111_1111_1111_1110, 16'h0007, "blank_7_a");
    check_frame(1, 16'b0111_1011_1101_1110, 16'h0007, "noblank_7_b");
  endtask

  task automatic test_saturation();
    int bc, dc; logic rb;
    run_load(14'd12000, 0, 14'd0, 0, bc, dc, rb);
    n_cmp++; if (bus_a.ovf !== 1'b1) begin n_err++; $display("FAIL sat ovf: got %b expected 1", bus_a.ovf); end
    check_frame(0, 16'b0111_1011_1101_1110, 16'h9999, "sat_12000_a");
    run_load(14'd50, 0, 14'd0, 0, bc, dc, rb);
    n_cmp++; if (bus_a.ovf !== 1'b0) begin n_err++; $display("FAIL sat ovf_clear: got %b expected 0", bus_a.ovf); end
    check_frame(0, 16'b1111_1111_1101_1110, 16'h0050, "val_50_a");
    check_frame(1, 16'b0111_1011_1101_1110, 16'h0050, "val_50_b");
  endtask

  task automatic test_ignored_load();
    int bc, dc; logic rb;
    run_load(14'd1234, 5, 14'd5678, 0, bc, dc, rb);
    n_cmp++; if (bc != 14) begin n_err++; $display("FAIL ignore busy_cycles: got %0d expected 14", bc); end
    n_cmp++; if (dc != 1) begin n_err++; $display("FAIL ignore done_pulses: got %0d expected 1", dc); end
    check_frame(0, 16'b0111_1011_1101_1110, 16'h1234, "ignore_a");
  endtask

  task automatic test_reset_mid_conv();
    int bc, dc; logic rb;
    run_load(14'd5678, 0, 14'd0, 7, bc, dc, rb);
    n_cmp++; if (rb !== 1'b0) begin n_err++; $display("FAIL rstmid busy_after: got %b expected 0", rb); end
    n_cmp++; if (dc != 0) begin n_err++; $display("FAIL rstmid done_pulses: got %0d expected 0", dc); end
    n_cmp++; if (bc != 7) begin n_err++; $display("FAIL rstmid busy_cycles: got %0d expected 7", bc); end
    check_frame(0, 16'b1111_1111_1111_1110, 16'h0000, "rstmid_a");
    // Reset wins over a load presented on the same edge.
    @(negedge clk);
    rst = 1'b1; bus_a.value = 14'd99; bus_b.value = 14'd99; bus_a.load = 1'b1; bus_b.load = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus_a.load = 1'b0; bus_b.load = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus_a.busy !== 1'b0) begin n_err++; $display("FAIL rst_load busy: got %b expected 0", bus_a.busy); end
    check_frame(0, 16'b1111_1111_1111_1110, 16'h0000, "rst_load_a");
  endtask

  initial begin
    bus_a.value = '0; bus_a.load = 1'b0;
    bus_b.value = '0; bus_b.load = 1'b0;
    test_reset();
    test_conversion();
    test_blanking();
    test_saturation();
    test_ignored_load();
    test_reset_mid_conv();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
